// File: rtl/systolic_feeder_pkg.sv
// Shared constants for the systolic array feeder: FSM encoding and
// size helpers derived from the matrix dimension.
package systolic_feeder_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_FEED  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Operand bytes per run: A then B, both N x N.
    function automatic int byte_count(input int n);
        return 2 * n * n;
    endfunction

    // FEED cycles needed for the last operand pair to reach PE(N-1,N-1).
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_mux.sv
// One edge lane: presents ops[t-IDX] while that index lies inside the
// operand vector, zero otherwise, so lane IDX runs IDX cycles behind lane 0.
module skew_mux #(
    parameter int N         = 2,
    parameter int REG_WIDTH = 4,
    parameter int IDX       = 0,
    parameter int TW        = 2
) (
    input  logic                        en,
    input  logic [TW-1:0]               t,
    input  logic [N-1:0][REG_WIDTH-1:0] ops,
    output logic [REG_WIDTH-1:0]        op
);

    always_comb begin
        op = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == IDX + k) op = ops[k];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A and B from the UART byte stream, clears the PE accumulators,
// then feeds diagonally skewed operands into the west and north array edges.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N         = 2,
    parameter int REG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [N*REG_WIDTH-1:0] a_edge,
    output logic [N*REG_WIDTH-1:0] b_edge,
    output logic                   pe_clear,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int BYTES = byte_count(N);
    localparam int FEED  = feed_len(N);
    localparam int LW    = cnt_width(BYTES);
    localparam int TW    = cnt_width(FEED);

    logic [1:0]           state;
    logic [LW-1:0]        ld_cnt;
    logic [TW-1:0]        t;
    logic [REG_WIDTH-1:0] mem [BYTES];
    logic                 feeding;
    logic                 unused_rx_hi;

    // a_rows[i][k] = A[i][k]; b_cols[j][k] = B[k][j]
    logic [N-1:0][N-1:0][REG_WIDTH-1:0] a_rows;
    logic [N-1:0][N-1:0][REG_WIDTH-1:0] b_cols;

    assign unused_rx_hi = ^rx_data[7:REG_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_LOAD;
            ld_cnt  <= '0;
            t       <= '0;
            overrun <= 1'b0;
        end else begin
            if (rx_valid && state != ST_LOAD) overrun <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (rx_valid) begin
                        if (ld_cnt == LW'(BYTES - 1)) begin
                            ld_cnt <= '0;
                            state  <= ST_CLEAR;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    t     <= '0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (t == TW'(FEED - 1)) begin
                        t     <= '0;
                        state <= ST_DONE;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Operand storage is fully rewritten each run, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && rx_valid) mem[ld_cnt] <= rx_data[REG_WIDTH-1:0];
    end

    assign rx_ready = (state == ST_LOAD);
    assign pe_clear = (state == ST_CLEAR);
    assign busy     = (state == ST_CLEAR) || (state == ST_FEED);
    assign done     = (state == ST_DONE);
    assign feeding  = (state == ST_FEED);

    genvar r, c, g;
    generate
        for (r = 0; r < N; r++) begin : g_row
            for (c = 0; c < N; c++) begin : g_col
                assign a_rows[r][c] = mem[r*N + c];
                assign b_cols[c][r] = mem[N*N + r*N + c];
            end
        end

        for (g = 0; g < N; g++) begin : g_lane
            skew_mux #(.N(N), .REG_WIDTH(REG_WIDTH), .IDX(g), .TW(TW)) u_west (
                .en  (feeding),
                .t   (t),
                .ops (a_rows[g]),
                .op  (a_edge[g*REG_WIDTH +: REG_WIDTH])
            );
            skew_mux #(.N(N), .REG_WIDTH(REG_WIDTH), .IDX(g), .TW(TW)) u_north (
                .en  (feeding),
                .t   (t),
                .ops (b_cols[g]),
                .op  (b_edge[g*REG_WIDTH +: REG_WIDTH])
            );
        end
    endgenerate

endmodule
